// File: rtl/dm_arbiter_pkg.sv
// Shared defaults and FSM encoding for the data-memory arbiter.
package dm_arb_pkg;
  localparam int NUM_CORES_DEF = 4;
  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/dm_arbiter_if.sv
// Core-side request bus plus data-memory port of the arbiter.
interface dm_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
);
  logic [NUM_CORES-1:0]             req;
  logic [NUM_CORES-1:0]             we;
  logic [NUM_CORES-1:0][ADDR_W-1:0] addr;
  logic [NUM_CORES-1:0][DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0]             done_in;
  logic [NUM_CORES-1:0]             ack;
  logic [DATA_W-1:0]                rdata;
  logic                             mem_we;
  logic [ADDR_W-1:0]                mem_addr;
  logic [DATA_W-1:0]                mem_wdata;
  logic [DATA_W-1:0]                mem_rdata;
  logic [NUM_CORES-1:0]             core_done;
  logic                             all_done;

  modport slave (
    input  req, we, addr, wdata, done_in, mem_rdata,
    output ack, rdata, mem_we, mem_addr, mem_wdata, core_done, all_done
  );

  modport master (
    output req, we, addr, wdata, done_in, mem_rdata,
    input  ack, rdata, mem_we, mem_addr, mem_wdata, core_done, all_done
  );
endinterface

// File: rtl/dm_arbiter_rr_picker.sv
// Combinational round-robin chooser: first eligible index after last_i, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [CW-1:0] last_i,
  output logic [CW-1:0] idx_o,
  output logic          vld_o
);
  logic [CW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = CW'((int'(last_i) + k) % N);
      if (elig_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dm_arbiter.sv
// Shared data-memory arbiter: round-robin grant, one access per 4-cycle
// IDLE/ACCESS/WAIT/RESP sequence, sticky per-core done flags.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  dm_arbiter_if.slave  bus
);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        grant_q, last_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q, rdata_q;
  logic [NUM_CORES-1:0] done_q, elig, ack_d;
  logic [CW-1:0]        pick_idx;
  logic                 pick_vld;

  assign elig = bus.req & ~done_q;

  rr_picker #(.N(NUM_CORES), .CW(CW)) u_pick (
    .elig_i (elig),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE:    if (pick_vld) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP: begin
        state_d        = IDLE;
        ack_d[grant_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= CW'(NUM_CORES - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_q | bus.done_in;
      // Snapshot the winner so input changes mid-access have no effect.
      if (state_q == IDLE && pick_vld) begin
        grant_q <= pick_idx;
        we_q    <= bus.we[pick_idx];
        addr_q  <= bus.addr[pick_idx];
        wdata_q <= bus.wdata[pick_idx];
      end
      if (state_q == WAIT && !we_q) rdata_q <= bus.mem_rdata;
      if (state_q == RESP)          last_q  <= grant_q;
    end
  end

  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
  assign bus.mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
  assign bus.ack       = ack_d;
  assign bus.rdata     = rdata_q;
  assign bus.core_done = done_q;
  assign bus.all_done  = &done_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: scoreboard of expected acks/read data,
// synchronous-read memory model, latency and masking checks.
module tb_dm_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dm_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dm_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] mem [0:255];
  always @(posedge clock) begin
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [N-1:0]  ack;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  int checks = 0, passes = 0, fails = 0, wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ack pops one expected grant/read-data pair.
  always @(negedge clock) begin
    exp_t e;
    if (bus.mem_we) wr_cnt++;
    if (reset_n && bus.ack != '0) begin
      if (sb.size() == 0) check("ack_unexpected", 32'(bus.ack), 32'd0);
      else begin
        e = sb.pop_front();
        check("ack_core", 32'(bus.ack), 32'(e.ack));
        check("ack_rdata", 32'(bus.rdata), 32'(e.rdata));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(output int at);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus.ack != '0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_req(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[c]   = 1'b1;
    bus.we[c]    = w;
    bus.addr[c]  = a;
    bus.wdata[c] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, prev, w0;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.done_in = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 16'h1234;
    for (int i = 0; i < N; i++) mem[8'h20 + i] = 16'hA000 + 16'(i);
    mem[8'h30] = 16'h5A5A;
    mem[8'h40] = 16'hC3C3;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_core_done", 32'(bus.core_done), 32'd0);
    check("rst_all_done", 32'(bus.all_done), 32'd0);
    step();
    reset_n = 1'b1;

    // Single read by core 2
    step();
    set_req(2, 1'b0, 8'h10, 16'h0);
    sb.push_back('{4'b0100, 16'h1234});
    t0 = cyc;
    @(negedge clock);
    @(negedge clock);
    check("rd_mem_addr", 32'(bus.mem_addr), 32'h10);
    check("rd_mem_we", 32'(bus.mem_we), 32'd0);
    wait_ack(t1);
    check("rd_latency", 32'(t1 - t0), 32'd3);
    step();
    bus.req[2] = 1'b0;

    // Single write by core 0, then readback through core 1
    w0 = wr_cnt;
    step();
    set_req(0, 1'b1, 8'h05, 16'hBEEF);
    sb.push_back('{4'b0001, 16'h1234});
    t0 = cyc;
    @(negedge clock);
    check("wr_idle_mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clock);
    check("wr_mem_we", 32'(bus.mem_we), 32'd1);
    check("wr_mem_addr", 32'(bus.mem_addr), 32'h05);
    check("wr_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    wait_ack(t1);
    check("wr_latency", 32'(t1 - t0), 32'd3);
    step();
    bus.req[0] = 1'b0;
    bus.we[0]  = 1'b0;
    check("wr_count", 32'(wr_cnt - w0), 32'd1);
    step();
    set_req(1, 1'b0, 8'h05, 16'h0);
    sb.push_back('{4'b0010, 16'hBEEF});
    wait_ack(t1);
    step();
    bus.req[1] = 1'b0;

    // Contention from reset: round-robin 0,1,2,3,0 at 4-cycle spacing
    do_reset();
    step();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h20 + i), 16'h0);
    for (int i = 0; i < N; i++) sb.push_back('{4'(1 << i), 16'(16'hA000 + i)});
    sb.push_back('{4'b0001, 16'hA000});
    t0 = cyc;
    prev = t0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(t1);
      if (k == 0) check("rr_latency", 32'(t1 - t0), 32'd3);
      else        check("rr_spacing", 32'(t1 - prev), 32'd4);
      prev = t1;
    end
    step();
    bus.req = '0;

    // Done masking: core 1 finished, only core 0 served; done during grant
    step();
    bus.done_in[1] = 1'b1;
    step();
    bus.done_in = '0;
    @(negedge clock);
    check("dm_core_done1", 32'(bus.core_done), 32'b0010);
    check("dm_all_done0", 32'(bus.all_done), 32'd0);
    step();
    set_req(0, 1'b0, 8'h30, 16'h0);
    set_req(1, 1'b0, 8'h31, 16'h0);
    for (int i = 0; i < 3; i++) sb.push_back('{4'b0001, 16'h5A5A});
    wait_ack(prev);
    wait_ack(t1);
    check("dm_spacing", 32'(t1 - prev), 32'd4);
    prev = t1;
    step();
    step();
    bus.done_in[0] = 1'b1;
    step();
    bus.done_in = '0;
    wait_ack(t1);
    check("dm_done_in_grant", 32'(t1 - prev), 32'd4);
    repeat (8) @(negedge clock);
    check("dm_sb_empty", 32'(sb.size()), 32'd0);
    check("dm_core_done01", 32'(bus.core_done), 32'b0011);
    step();
    bus.req = '0;
    bus.done_in[2] = 1'b1;
    step();
    bus.done_in = '0;
    @(negedge clock);
    check("dm_all_done_3of4", 32'(bus.all_done), 32'd0);
    step();
    bus.done_in[3] = 1'b1;
    step();
    bus.done_in = '0;
    @(negedge clock);
    check("dm_all_done", 32'(bus.all_done), 32'd1);
    check("dm_core_done_all", 32'(bus.core_done), 32'b1111);

    // Reset during WAIT of a core 3 read
    do_reset();
    @(negedge clock);
    check("mr_core_done_clr", 32'(bus.core_done), 32'd0);
    step();
    set_req(3, 1'b0, 8'h40, 16'h0);
    @(negedge clock);
    @(negedge clock);
    check("mr_access_addr", 32'(bus.mem_addr), 32'h40);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mr_ack", 32'(bus.ack), 32'd0);
    check("mr_mem_we", 32'(bus.mem_we), 32'd0);
    check("mr_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("mr_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("mr_rdata", 32'(bus.rdata), 32'd0);
    repeat (2) @(posedge clock);
    sb.push_back('{4'b1000, 16'hC3C3});
    step();
    reset_n = 1'b1;
    t0 = cyc;
    wait_ack(t1);
    check("mr_latency", 32'(t1 - t0), 32'd3);
    step();
    bus.req = '0;
    repeat (3) @(negedge clock);
    check("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
